// File: rtl/seg_scan_driver_pkg.sv
// Shared types, segment table and hex decoder for the seven-segment scan driver.
package seg_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    LIT   = 2'd1,
    DARK  = 2'd2
  } scan_state_t;

  typedef logic [6:0] seg_t;

  // One committed or pending display image, as captured on load.
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dig_en;
    logic [3:0]  dp;
    logic [3:0]  bright;
  } disp_cfg_t;

  // GFEDCBA, active-high, indexed by hex nibble.
  localparam seg_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex2seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side load bus and active-low display pins of the scan driver.
interface seg_scan_driver_if;
  import seg_pkg::*;

  logic        load;
  logic [15:0] value;
  logic [3:0]  dig_en;
  logic [3:0]  dp_in;
  logic [3:0]  bright;
  seg_t        display_data;
  logic        dp_n;
  logic [3:0]  select;
  logic        frame_done;
  logic        pending;

  modport master (
    output load, value, dig_en, dp_in, bright,
    input  display_data, dp_n, select, frame_done, pending
  );

  modport slave (
    input  load, value, dig_en, dp_in, bright,
    output display_data, dp_n, select, frame_done, pending
  );

endinterface

// File: rtl/seg_scan_driver_tick_gen.sv
// Scan prescaler: tick is a registered one-clock pulse every PRESCALE clocks;
// tick_pre is its combinational look-ahead, high the cycle before tick.
module seg_tick_gen #(
  parameter int PRESCALE = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic tick_pre
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("seg_tick_gen: PRESCALE must be at least 2");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick     = tick_q;
  assign tick_pre = tick_d;

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan with per-slot blanking, PWM brightness and frame-aligned commits.
// Pins are registered and lag the scan FSM by one clock; the load bus is always accepted.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int PRESCALE    = 1024,
  parameter int SLOT_TICKS  = 16,
  parameter int BLANK_TICKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave bus
);

  localparam int TW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [TW-1:0] T_LAST     = TW'(SLOT_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

  if (BLANK_TICKS < 1) begin : g_bad_blank_min
    $error("seg_scan_driver: BLANK_TICKS must be at least 1");
  end
  if (BLANK_TICKS + 15 > SLOT_TICKS) begin : g_bad_blank_fit
    $error("seg_scan_driver: BLANK_TICKS+15 must not exceed SLOT_TICKS");
  end

  logic tick, tick_pre;

  seg_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .tick_pre (tick_pre)
  );

  disp_cfg_t   in_cfg;
  disp_cfg_t   pend_q, pend_d;
  disp_cfg_t   sh_q, sh_d;
  logic        pending_q, pending_d;
  scan_state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [1:0]  dig_q, dig_d;
  logic [3:0]  lit_q, lit_d;
  logic        fd_q, fd_d;
  logic [3:0]  sel_q, sel_d;
  seg_t        seg_q, seg_d;
  logic        dpn_q, dpn_d;
  logic        slot_end;
  logic [3:0]  nib;

  assign in_cfg = '{value: bus.value, dig_en: bus.dig_en, dp: bus.dp_in, bright: bus.bright};

  // Slot timing and per-slot PWM state machine.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    dig_d    = dig_q;
    lit_d    = lit_q;
    slot_end = (t_q == T_LAST);
    if (tick) begin
      t_d = slot_end ? '0 : t_q + 1'b1;
      if (slot_end) begin
        dig_d = dig_q + 1'b1;
      end
      case (state_q)
        BLANK: begin
          if (t_q == BLANK_LAST) begin
            state_d = (sh_q.bright != 4'd0) ? LIT : DARK;
            lit_d   = '0;
          end
        end
        LIT: begin
          if (slot_end) begin
            state_d = BLANK;
          end else if (lit_q == (sh_q.bright - 4'd1)) begin
            state_d = DARK;
          end else begin
            lit_d = lit_q + 1'b1;
          end
        end
        DARK: begin
          if (slot_end) begin
            state_d = BLANK;
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  // frame_done is registered from the look-ahead so it coincides with the wrapping tick.
  assign fd_d = tick_pre && (t_q == T_LAST) && (dig_q == 2'd3);

  // Coincident load and frame boundary bypasses the pending stage.
  always_comb begin
    pend_d    = pend_q;
    sh_d      = sh_q;
    pending_d = pending_q;
    if (bus.load && fd_q) begin
      sh_d      = in_cfg;
      pending_d = 1'b0;
    end else if (bus.load) begin
      pend_d    = in_cfg;
      pending_d = 1'b1;
    end else if (fd_q && pending_q) begin
      sh_d      = pend_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    nib   = sh_q.value[{dig_q, 2'b00} +: 4];
    sel_d = 4'hF;
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if ((state_q == LIT) && sh_q.dig_en[dig_q]) begin
      sel_d = ~(4'b0001 << dig_q);
      seg_d = ~hex2seg(nib);
      dpn_d = ~sh_q.dp[dig_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q    <= '0;
      sh_q      <= '0;
      pending_q <= 1'b0;
      state_q   <= BLANK;
      t_q       <= '0;
      dig_q     <= 2'd0;
      lit_q     <= 4'd0;
      fd_q      <= 1'b0;
      sel_q     <= 4'hF;
      seg_q     <= 7'h7F;
      dpn_q     <= 1'b1;
    end else begin
      pend_q    <= pend_d;
      sh_q      <= sh_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      t_q       <= t_d;
      dig_q     <= dig_d;
      lit_q     <= lit_d;
      fd_q      <= fd_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      dpn_q     <= dpn_d;
    end
  end

  assign bus.display_data = seg_q;
  assign bus.dp_n         = dpn_q;
  assign bus.select       = sel_q;
  assign bus.frame_done   = fd_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: expected lit runs are queued at each commit and matched as the pins light.
module tb_seg_scan_driver;

  localparam int PRESCALE   = 4;
  localparam int SLOT       = 16;
  localparam int BLANK      = 1;
  localparam int FRAME_CLKS = PRESCALE * SLOT * 4;
  localparam int GAP_MIN    = BLANK * PRESCALE;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic [3:0]  bright;
  } cfg_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        dpn;
    logic [15:0] len;
  } run_t;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .PRESCALE    (PRESCALE),
    .SLOT_TICKS  (SLOT),
    .BLANK_TICKS (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model of load/commit and the queue of expected lit runs.
  cfg_t   m_pend, m_shadow, cur_in;
  logic   m_pending;
  run_t   exp_q[$];
  logic   run_act, run_chg, load_prev, fd_prev;
  run_t   run_obs;
  int     cyc, f_cnt;

  task automatic push_frame(input cfg_t c);
    for (int i = 0; i < 4; i++) begin
      run_t r;
      if (c.bright != 4'd0 && c.en[i]) begin
        r.sel = ~(4'b0001 << i);
        r.seg = ~SEG_TBL[c.value[i*4 +: 4]];
        r.dpn = ~c.dp[i];
        r.len = 16'(c.bright * PRESCALE);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic end_run();
    run_t e;
    check("dark_seg", bus.display_data, 7'h7F);
    check("dark_dp", bus.dp_n, 1'b1);
    if (exp_q.size() == 0) begin
      check("unexpected_run", run_obs.sel, 4'hF);
    end else begin
      e = exp_q.pop_front();
      check("run_sel", run_obs.sel, e.sel);
      check("run_seg", run_obs.seg, e.seg);
      check("run_dpn", run_obs.dpn, e.dpn);
      check("run_len", run_obs.len, e.len);
      check("run_stable", run_chg, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_pend    = '0;
      m_shadow  = '0;
      m_pending = 1'b0;
      exp_q.delete();
      run_act   = 1'b0;
      run_chg   = 1'b0;
      load_prev = 1'b0;
      fd_prev   = 1'b0;
      cyc       = 0;
      f_cnt     = 0;
    end else begin
      cyc++;
      cur_in = {bus.value, bus.dig_en, bus.dp_in, bus.bright};
      if (bus.load || bus.frame_done || load_prev || fd_prev)
        check("pending", bus.pending, m_pending);
      load_prev = bus.load;
      fd_prev   = bus.frame_done;
      if (bus.frame_done) begin
        check("fd_period", cyc, FRAME_CLKS);
        cyc = 0;
      end
      if (bus.load && bus.frame_done) begin
        m_shadow  = cur_in;
        m_pending = 1'b0;
      end else if (bus.load) begin
        m_pend    = cur_in;
        m_pending = 1'b1;
      end else if (bus.frame_done && m_pending) begin
        m_shadow  = m_pend;
        m_pending = 1'b0;
      end
      if (bus.frame_done) push_frame(m_shadow);

      if (bus.select != 4'hF) begin
        if (!run_act) begin
          run_act     = 1'b1;
          run_chg     = 1'b0;
          run_obs.sel = bus.select;
          run_obs.seg = bus.display_data;
          run_obs.dpn = bus.dp_n;
          run_obs.len = '0;
          check("one_hot_zero", $countones(~bus.select), 1);
          check("gap_min", (f_cnt >= GAP_MIN), 1'b1);
        end else if (bus.select != run_obs.sel || bus.display_data != run_obs.seg ||
                     bus.dp_n != run_obs.dpn) begin
          run_chg = 1'b1;
        end
        run_obs.len++;
        f_cnt = 0;
      end else begin
        if (run_act) begin
          end_run();
          run_act = 1'b0;
        end
        f_cnt++;
      end
    end
  end

  task automatic wait_fd(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.frame_done && k < 2 * FRAME_CLKS);
    check(tag, bus.frame_done, 1'b1);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_cfg(input cfg_t c);
    bus.value  = c.value;
    bus.dig_en = c.en;
    bus.dp_in  = c.dp;
    bus.bright = c.bright;
  endtask

  task automatic do_load(input cfg_t c);
    @(posedge clk);
    #1;
    drive_cfg(c);
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic load_on_fd(input cfg_t c);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!bus.frame_done && k < 2 * FRAME_CLKS);
    check("fd_align", bus.frame_done, 1'b1);
    drive_cfg(c);
    bus.load = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.load   = 1'b0;
    bus.value  = '0;
    bus.dig_en = '0;
    bus.dp_in  = '0;
    bus.bright = '0;

    // 1: reset values, then idle frames with nothing shown
    repeat (3) @(negedge clk);
    check("rst_seg", bus.display_data, 7'h7F);
    check("rst_dp", bus.dp_n, 1'b1);
    check("rst_sel", bus.select, 4'hF);
    check("rst_fd", bus.frame_done, 1'b0);
    check("rst_pend", bus.pending, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) wait_fd("idle_fd");

    // 2: full brightness with decimal point on digit 2
    wait_clks(100);
    do_load('{value: 16'h1A3F, en: 4'hF, dp: 4'b0100, bright: 4'd15});
    wait_fd("t2_commit");
    wait_fd("t2_frame");

    // 3: reduced brightness, then off
    wait_clks(40);
    do_load('{value: 16'h1A3F, en: 4'hF, dp: 4'b0100, bright: 4'd4});
    wait_fd("t3_commit");
    wait_fd("t3_frame");
    wait_clks(40);
    do_load('{value: 16'h1A3F, en: 4'hF, dp: 4'b0100, bright: 4'd0});
    wait_fd("t3_off_commit");
    wait_fd("t3_off_frame");
    wait_clks(3);
    drain_check("t3_drained");

    // 4: two loads in one frame, last one wins
    wait_clks(40);
    do_load('{value: 16'h0000, en: 4'hF, dp: 4'b0000, bright: 4'd2});
    wait_clks(30);
    do_load('{value: 16'h8888, en: 4'hF, dp: 4'b0000, bright: 4'd2});
    wait_fd("t4_commit");
    wait_fd("t4_frame");

    // 5: load exactly on frame_done bypasses pending
    load_on_fd('{value: 16'h5555, en: 4'hF, dp: 4'b0000, bright: 4'd3});
    wait_fd("t5_frame");

    // 6: asynchronous reset while digit 1 is lit
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.select !== 4'hD && k < 2 * FRAME_CLKS);
    check("t6_sel_d_seen", bus.select, 4'hD);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_sel", bus.select, 4'hF);
    check("t6_rst_seg", bus.display_data, 7'h7F);
    check("t6_rst_dp", bus.dp_n, 1'b1);
    check("t6_rst_fd", bus.frame_done, 1'b0);
    check("t6_rst_pend", bus.pending, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_fd("t6_fd1");
    wait_fd("t6_fd2");
    wait_clks(3);
    drain_check("t6_drained");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
